// File: rtl/dot11_tx_sched.sv
// Frame scheduler for the dot11_tx engine: round-robin queue grant, start/done
// handshake with watchdog, engine reset on timeout, and inter-frame gap.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame; wait for enable & any request
// ARB     | pick next queue round-robin, latch grant and seed
// START   | one-cycle phy_tx_start pulse
// WAIT_ST | wait for phy_tx_started, bounded by START_TO
// WAIT_DN | wait for phy_tx_done, bounded by DONE_TO
// ENG_RST | err_pulse cycle, then phy_tx_arest for RST_CYC cycles
// GAP     | IFS_CYC idle cycles before the next arbitration
module dot11_tx_sched #(
   parameter int NUM_Q    = 4,
   parameter int START_TO = 64,
   parameter int DONE_TO  = 100000,
   parameter int IFS_CYC  = 16,
   parameter int RST_CYC  = 4
) (
   input  logic                     clk,
   input  logic                     tx_arest_n,
   input  logic                     enable,
   input  logic [NUM_Q-1:0]         req,
   output logic [NUM_Q-1:0]         grant,
   output logic [$clog2(NUM_Q)-1:0] grant_idx,
   output logic [NUM_Q-1:0]         done_pulse,
   output logic [NUM_Q-1:0]         err_pulse,
   output logic                     busy,
   output logic                     phy_tx_start,
   input  logic                     phy_tx_started,
   input  logic                     phy_tx_done,
   output logic                     phy_tx_arest,
   output logic [6:0]               init_pilot_scram_state,
   output logic [6:0]               init_data_scram_state
);

   localparam int              IW        = $clog2(NUM_Q);
   localparam logic [16:0]     CNT_MAX   = '1;
   localparam logic [16:0]     START_LIM = 17'(START_TO);
   localparam logic [16:0]     DONE_LIM  = 17'(DONE_TO);
   localparam logic [16:0]     RST_LIM   = 17'(RST_CYC);
   localparam logic [16:0]     IFS_LAST  = 17'(IFS_CYC - 1);
   localparam logic [IW-1:0]   LAST_Q    = IW'(NUM_Q - 1);
   localparam logic [6:0]      SEED_RST  = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_WAIT_ST,
      S_WAIT_DN,
      S_ENG_RST,
      S_GAP
   } state_t;

   state_t            state, state_nxt;
   logic [16:0]       cnt, cnt_nxt, cnt_inc;
   logic [IW-1:0]     rr_ptr, rr_nxt;
   logic [IW-1:0]     win_idx, cand, idx_nxt;
   logic              win_found;
   logic [NUM_Q-1:0]  grant_nxt, done_nxt, err_nxt;
   logic [6:0]        seed, seed_nxt;

   assign init_pilot_scram_state = 7'h7F;
   assign init_data_scram_state  = seed;

   // First requesting queue at or after rr_ptr, wrapping modulo NUM_Q.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (int'(rr_ptr) + i >= NUM_Q)
            cand = IW'(int'(rr_ptr) + i - NUM_Q);
         else
            cand = IW'(int'(rr_ptr) + i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 17'd1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      rr_nxt    = rr_ptr;
      idx_nxt   = grant_idx;
      seed_nxt  = seed;
      grant_nxt = grant;
      done_nxt  = '0;
      err_nxt   = '0;

      // grant is held through the pulse cycle and dropped right after it
      if (|done_pulse || |err_pulse)
         grant_nxt = '0;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (enable && |req)
               state_nxt = S_ARB;
         end
         S_ARB: begin
            cnt_nxt = '0;
            if (win_found) begin
               grant_nxt          = '0;
               grant_nxt[win_idx] = 1'b1;
               idx_nxt            = win_idx;
               rr_nxt             = (win_idx == LAST_Q) ? '0 : win_idx + 1'b1;
               seed_nxt           = {seed[5:0], seed[6] ^ seed[3]};
               state_nxt          = S_START;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_START: begin
            state_nxt = S_WAIT_ST;
         end
         S_WAIT_ST: begin
            if (phy_tx_started && phy_tx_done) begin
               done_nxt  = grant;
               cnt_nxt   = '0;
               state_nxt = S_GAP;
            end else if (phy_tx_started) begin
               cnt_nxt   = '0;
               state_nxt = S_WAIT_DN;
            end else if (cnt_inc == START_LIM) begin
               err_nxt   = grant;
               cnt_nxt   = '0;
               state_nxt = S_ENG_RST;
            end
         end
         S_WAIT_DN: begin
            if (phy_tx_done) begin
               done_nxt  = grant;
               cnt_nxt   = '0;
               state_nxt = S_GAP;
            end else if (cnt_inc == DONE_LIM) begin
               err_nxt   = grant;
               cnt_nxt   = '0;
               state_nxt = S_ENG_RST;
            end
         end
         S_ENG_RST: begin
            // cycle 0 carries err_pulse; cycles 1..RST_CYC carry phy_tx_arest
            if (cnt == RST_LIM) begin
               cnt_nxt   = '0;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt == IFS_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge tx_arest_n) begin
      if (!tx_arest_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         rr_ptr       <= '0;
         seed         <= SEED_RST;
         grant        <= '0;
         grant_idx    <= '0;
         done_pulse   <= '0;
         err_pulse    <= '0;
         busy         <= 1'b0;
         phy_tx_start <= 1'b0;
         phy_tx_arest <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         rr_ptr       <= rr_nxt;
         seed         <= seed_nxt;
         grant        <= grant_nxt;
         grant_idx    <= idx_nxt;
         done_pulse   <= done_nxt;
         err_pulse    <= err_nxt;
         busy         <= (state_nxt != S_IDLE);
         phy_tx_start <= (state_nxt == S_START);
         phy_tx_arest <= (state == S_ENG_RST) && (state_nxt == S_ENG_RST);
      end
   end

endmodule
